hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core.
- Generates the stall, flush and bubble controls that sequence the PC, IF/ID and ID/EX pipeline registers.
- Covers three cases: load-use hazards, taken-branch flushes resolved in EX, and a multi-cycle mult/div unit tracked by an internal FSM.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MD_CYCLES, 8: number of cycles the mult/div unit is busy after issue; legal range is 1 to 2^CNT_W.
- CNT_W, 5: width of the mult/div down-counter.
- PERF_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- r  in  1  reset, synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  instruction in ID reads rs.
- id_uses_rt  in  1  instruction in ID reads rt.
- id_md_start  in  1  instruction in ID is mult/multu/div/divu.
- id_md_use  in  1  instruction in ID is mfhi/mflo/mthi/mtlo.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- ex_br_taken  in  1  branch or jump in EX is taken.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  clear IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX; the top level ORs this with r into the ID/EX reset input.
- md_busy  out  1  mult/div unit busy.
- md_done  out  1  last busy cycle of the mult/div unit.
- stall_count  out  PERF_W  number of stalled cycles, saturating.

Behaviour:
- Reset (r=1 at a clk edge) sets:
  - state to IDLE, cnt to 0, stall_count to 0;
  - md_busy=0 and md_done=0 from the next cycle.
- Reset in the middle of a mult/div operation aborts it immediately; there is no pending done.
- Combinational hazard terms, evaluated each cycle:
  - load_use = ex_memread & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
  - md_hazard = md_busy & (id_md_start | id_md_use).
  - stall = (load_use | md_hazard) & ~ex_br_taken.
- Combinational outputs:
  - pc_we = ~stall; ifid_we = ~stall.
  - ifid_flush = ex_br_taken.
  - idex_bubble = stall | ex_br_taken.
- Priority: a taken branch overrides any stall, because the stalled instruction is on the wrong path and is being flushed.
- Register $0 never creates a load-use hazard.
- FSM, states IDLE and BUSY:
  - Issue condition: id_md_start & ~stall & ~ex_br_taken.
  - IDLE, issue at cycle T: go to BUSY and load cnt = MD_CYCLES-1. md_busy is 1 in cycles T+1 through T+MD_CYCLES.
  - BUSY, cnt != 0: decrement cnt.
  - BUSY, cnt == 0: return to IDLE.
  - md_busy = (state == BUSY).
  - md_done = BUSY & (cnt == 0), a one-cycle pulse in cycle T+MD_CYCLES.
  - A dependent mfhi/mflo or a second mult/div held in ID stalls for the whole busy window, including the md_done cycle. It proceeds in the first IDLE cycle, where it may re-issue back-to-back.
- Independent instructions continue to flow while md_busy is 1.
- stall_count increments on every clock edge at which stall=1 and r=0. It saturates at all-ones and does not wrap.
- Boundary cases:
  - load_use and md_hazard together: a single stall is raised and the counter increments once.
  - ex_br_taken during BUSY: the FSM keeps counting, because an issued mult/div is architecturally committed.
  - MD_CYCLES=1: BUSY lasts exactly one cycle, with md_done=1 in that cycle.

Test Plan:
1. Reset behaviour: assert r for 2 cycles mid-BUSY (cnt=3) -> next cycle md_busy=0, md_done=0, stall_count=0, pc_we=1.
2. Load-use hazard:
   - ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> pc_we=0, ifid_we=0, idex_bubble=1, stall_count increments by 1.
   - Same stimulus with ex_rt=0 -> no stall.
3. Taken branch over stall: same load-use condition as scenario 2 plus ex_br_taken=1 -> pc_we=1, ifid_flush=1, idex_bubble=1, stall_count unchanged.
4. Mult/div sequencing, MD_CYCLES=8: issue at T, then id_md_use=1 from T+1 -> md_busy=1 for T+1 through T+8, md_done=1 only at T+8, stall=1 for T+1 through T+8, stall=0 at T+9, stall_count=8.
5. Back-to-back mult/div: second id_md_start held in ID during BUSY -> stalls until IDLE, issues at T+9, md_done next at T+17. An independent instruction (flags all 0) during BUSY sees pc_we=1.
6. Counter saturation: with PERF_W=4, hold the stall condition for 20 cycles -> stall_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use stalls,
// taken-branch flushes and mult/div busy tracking, plus a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned MD_CYCLES = 8,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned PERF_W    = 16
) (
  input  logic              clk,
  input  logic              r,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_md_start,
  input  logic              id_md_use,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              ex_br_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PERF_W-1:0]  r_stall_count;

  logic w_load_use;
  logic w_md_hazard;
  logic w_stall;
  logic w_issue;
  logic w_busy;

  always_comb begin
    w_busy      = (r_state == BUSY);
    w_load_use  = ex_memread && (ex_rt != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rt)) ||
                   (id_uses_rt && (id_rt == ex_rt)));
    w_md_hazard = w_busy && (id_md_start || id_md_use);
    // A taken branch squashes the stalled instruction, so it never stalls.
    w_stall     = (w_load_use || w_md_hazard) && !ex_br_taken;
    w_issue     = id_md_start && !w_stall && !ex_br_taken;
  end

  always_comb begin
    pc_we       = !w_stall;
    ifid_we     = !w_stall;
    ifid_flush  = ex_br_taken;
    idex_bubble = w_stall || ex_br_taken;
    md_busy     = w_busy;
    md_done     = w_busy && (r_cnt == '0);
    stall_count = r_stall_count;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = MD_LOAD;
        end
      end
      BUSY: begin
        // An issued operation always runs to completion, even across a flush.
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a default instance (MD_CYCLES=8)
// and a small instance (MD_CYCLES=1, PERF_W=4) driven by the same inputs.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       r;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_md_start, id_md_use, ex_memread, ex_br_taken;

  logic        m_pc_we, m_ifid_we, m_ifid_flush, m_idex_bubble, m_md_busy, m_md_done;
  logic [15:0] m_stall_count;
  logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_md_busy, s_md_done;
  logic [3:0]  s_stall_count;

  hazard_stall_ctrl #(.MD_CYCLES(8), .CNT_W(5), .PERF_W(16)) u_main (
    .clk(clk), .r(r), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .id_md_use(id_md_use),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .pc_we(m_pc_we), .ifid_we(m_ifid_we), .ifid_flush(m_ifid_flush),
    .idex_bubble(m_idex_bubble), .md_busy(m_md_busy), .md_done(m_md_done),
    .stall_count(m_stall_count)
  );

  hazard_stall_ctrl #(.MD_CYCLES(1), .CNT_W(5), .PERF_W(4)) u_sat (
    .clk(clk), .r(r), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .id_md_use(id_md_use),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .md_busy(s_md_busy), .md_done(s_md_done),
    .stall_count(s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mds, mdu, mrd;
    logic [4:0] exrt;
    logic       br;
    logic       pc_we, flush, bubble;
  } vec_t;

  typedef struct {
    logic        sat;
    logic        pc_we, flush, bubble, busy, done;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic exp_t mk(input logic sat, input logic pc_we, input logic flush,
                              input logic bubble, input logic busy, input logic done,
                              input int cnt, input string tag);
    exp_t e;
    e.sat = sat; e.pc_we = pc_we; e.flush = flush; e.bubble = bubble;
    e.busy = busy; e.done = done; e.cnt = 16'(cnt); e.tag = tag;
    return e;
  endfunction

  task automatic chk(input string nm, input string tag, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s got %0h want %0h at %0t", tag, nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mds, input logic mdu, input logic mrd,
                        input logic [4:0] exrt, input logic br);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_md_start = mds; id_md_use = mdu; ex_memread = mrd; ex_rt = exrt; ex_br_taken = br;
  endtask

  task automatic clr();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Inputs are set just after a rising edge; outputs are sampled at the falling edge.
  task automatic cycle_check(input exp_t e);
    exp_t g;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    if (g.sat) begin
      chk("pc_we", g.tag, {15'd0, s_pc_we}, {15'd0, g.pc_we});
      chk("ifid_we", g.tag, {15'd0, s_ifid_we}, {15'd0, g.pc_we});
      chk("ifid_flush", g.tag, {15'd0, s_ifid_flush}, {15'd0, g.flush});
      chk("idex_bubble", g.tag, {15'd0, s_idex_bubble}, {15'd0, g.bubble});
      chk("md_busy", g.tag, {15'd0, s_md_busy}, {15'd0, g.busy});
      chk("md_done", g.tag, {15'd0, s_md_done}, {15'd0, g.done});
      chk("stall_count", g.tag, {12'd0, s_stall_count}, g.cnt);
    end else begin
      chk("pc_we", g.tag, {15'd0, m_pc_we}, {15'd0, g.pc_we});
      chk("ifid_we", g.tag, {15'd0, m_ifid_we}, {15'd0, g.pc_we});
      chk("ifid_flush", g.tag, {15'd0, m_ifid_flush}, {15'd0, g.flush});
      chk("idex_bubble", g.tag, {15'd0, m_idex_bubble}, {15'd0, g.bubble});
      chk("md_busy", g.tag, {15'd0, m_md_busy}, {15'd0, g.busy});
      chk("md_done", g.tag, {15'd0, m_md_done}, {15'd0, g.done});
      chk("stall_count", g.tag, m_stall_count, g.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    r = 1'b1;
    @(posedge clk);
    #1;
    r = 1'b0;
  endtask

  vec_t tbl[10];
  int   exp_cnt;

  initial begin
    clr();
    r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    r = 1'b0;
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_main"));
    cycle_check(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_sat"));

    //          rs     rt     urs   urt   mds   mdu   mrd   exrt   br    pc_we flush bubble
    tbl[0] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{5'd1,  5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{5'd1,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{5'd5,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{5'd31, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].mds, tbl[i].mdu,
             tbl[i].mrd, tbl[i].exrt, tbl[i].br);
      cycle_check(mk(1'b0, tbl[i].pc_we, tbl[i].flush, tbl[i].bubble, 1'b0, 1'b0,
                     exp_cnt, $sformatf("vec%0d", i)));
      if (!tbl[i].pc_we) exp_cnt++;
    end

    // Reset in the middle of BUSY (cnt=3) aborts the operation.
    do_reset();
    id_md_start = 1'b1;
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rst_issue"));
    clr(); id_md_use = 1'b1;
    for (int k = 1; k <= 4; k++)
      cycle_check(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, k - 1, "rst_busy"));
    r = 1'b1;
    cycle_check(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, "rst_cnt3"));
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rst_hold"));
    r = 1'b0;
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rst_after"));
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rst_nodone"));

    // Dependent mfhi/mflo stalls across the whole busy window.
    do_reset();
    id_md_start = 1'b1;
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "md_issue"));
    clr(); id_md_use = 1'b1;
    for (int k = 1; k <= 8; k++)
      cycle_check(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'(k == 8), k - 1, $sformatf("md_T%0d", k)));
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, "md_T9"));
    clr();
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, "md_T10"));

    // Back-to-back mult/div, independent flow, and a branch during BUSY.
    do_reset();
    id_md_start = 1'b1;
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "b2b_issue"));
    clr();
    for (int k = 1; k <= 3; k++)
      cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, $sformatf("b2b_indep%0d", k)));
    id_md_start = 1'b1;
    for (int k = 4; k <= 8; k++)
      cycle_check(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'(k == 8), k - 4, $sformatf("b2b_T%0d", k)));
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, "b2b_reissue"));
    clr();
    for (int k = 10; k <= 17; k++) begin
      ex_br_taken = 1'(k == 11);
      cycle_check(mk(1'b0, 1'b1, 1'(k == 11), 1'(k == 11), 1'b1, 1'(k == 17), 5,
                     $sformatf("b2b_T%0d", k)));
    end
    clr();
    cycle_check(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, "b2b_T18"));

    // MD_CYCLES=1: busy and done together for exactly one cycle.
    do_reset();
    id_md_start = 1'b1;
    cycle_check(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "md1_issue"));
    clr(); id_md_use = 1'b1;
    cycle_check(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "md1_busy"));
    cycle_check(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, "md1_idle"));

    // Saturation of the 4-bit stall counter.
    do_reset();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    for (int k = 0; k < 20; k++)
      cycle_check(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (k < 15) ? k : 15,
                     $sformatf("sat%0d", k)));
    clr();
    cycle_check(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, "sat_hold"));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
